// File: rtl/isr_autopush.sv
// Input shift register for one PIO state machine, feeding the RX fifo.
// Assembles words from IN shifts, pushes on threshold (autopush) or on an
// explicit PUSH, supports MOV-to-ISR loads, and flags stalls/overflows.
module isr_autopush #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_bits,
  input  logic              shift_right,
  input  logic              autopush_en,
  input  logic [4:0]        push_thresh,
  input  logic              push_req,
  input  logic              push_iffull,
  input  logic              push_block,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear_overflow,
  input  logic              fifo_full,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] isr_value,
  output logic [CNT_W-1:0]  isr_count,
  output logic              stall,
  output logic              rx_overflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  logic [DATA_W-1:0] isr_q, isr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [CNT_W-1:0]  n_bits;
  logic [CNT_W-1:0]  thr;
  logic [CNT_W:0]    cnt_sum;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] in_mask;
  logic [DATA_W-1:0] shift_nxt;

  // A 5-bit field value of 0 stands for a full word.
  function automatic logic [CNT_W-1:0] decode_amt(input logic [4:0] v);
    return (v == 5'd0) ? FULL_CNT : CNT_W'(v);
  endfunction

  // The shift counter saturates at a full word instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W:0] s);
    return (s > {1'b0, FULL_CNT}) ? FULL_CNT : s[CNT_W-1:0];
  endfunction

  // Candidate ISR value and count if the IN command were to take effect.
  always_comb begin
    n_bits    = decode_amt(in_bits);
    thr       = decode_amt(push_thresh);
    cnt_sum   = {1'b0, count_q} + {1'b0, n_bits};
    cnt_nxt   = sat_count(cnt_sum);
    in_mask   = '0;
    shift_nxt = in_data;
    if (n_bits != FULL_CNT) begin
      in_mask = (DATA_W'(1) << n_bits) - DATA_W'(1);
      if (shift_right) begin
        shift_nxt = (isr_q >> n_bits) | (in_data << (FULL_CNT - n_bits));
      end else begin
        shift_nxt = (isr_q << n_bits) | (in_data & in_mask);
      end
    end
  end

  // Command arbitration (load > push > in) and fifo handshake.
  always_comb begin
    isr_d     = isr_q;
    count_d   = count_q;
    ovf_d     = ovf_q & ~clear_overflow;
    fifo_push = 1'b0;
    fifo_data = isr_q;
    stall     = 1'b0;
    if (!rst) begin
      if (load_en) begin
        isr_d   = load_data;
        count_d = '0;
      end else if (push_req) begin
        if (push_iffull && (count_q < thr)) begin
          // Below threshold: the PUSH retires without doing anything.
        end else if (!fifo_full) begin
          fifo_push = 1'b1;
          fifo_data = isr_q;
          isr_d     = '0;
          count_d   = '0;
        end else if (push_block) begin
          stall = 1'b1;
        end else begin
          // Non-blocking push into a full fifo loses the word; set wins over clear.
          isr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b1;
        end
      end else if (in_en) begin
        if (autopush_en && (cnt_nxt >= thr)) begin
          if (!fifo_full) begin
            fifo_push = 1'b1;
            fifo_data = shift_nxt;
            isr_d     = '0;
            count_d   = '0;
          end else begin
            stall = 1'b1;
          end
        end else begin
          isr_d   = shift_nxt;
          count_d = cnt_nxt;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      isr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      isr_q   <= isr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign isr_value   = isr_q;
  assign isr_count   = count_q;
  assign rx_overflow = ovf_q;

endmodule
